// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - UART-fed instruction memory program loader
//
// Waits for SYNC_BYTE, then packs received bytes into WORD_W-bit words and
// issues one instruction-memory write per completed word. Loading stops on
// an all-zero terminator word (DONE) or when a non-zero word lands on the
// last memory address (ERR with overflow).
//
// Optional feature: define LOADER_CHECKSUM_EN to add a CSUM state. In CSUM
// the byte following the terminator is compared against the running XOR of
// all data bytes; a mismatch goes to ERR and raises o_csum_err.
//
// Ports:
//   i_clk        clock, all logic on the rising edge
//   i_rst        synchronous active-high reset
//   i_rx_data    received byte
//   i_rx_valid   one-cycle strobe qualifying i_rx_data
//   i_start      one-cycle pulse, re-arms from DONE/ERR back to IDLE
//   o_wr_en      one-cycle memory write strobe
//   o_wr_addr    word address of the write
//   o_wr_data    assembled word
//   o_busy       high while receiving (and in CSUM)
//   o_done       high in DONE
//   o_err        high in ERR
//   o_overflow   sticky, set when ERR was caused by a full memory
//   o_word_count words written, including the terminator
//   o_csum_err   (LOADER_CHECKSUM_EN only) checksum mismatch flag

module inst_loader #(
  parameter int         WORD_W     = 32,
  parameter int         ADDR_W     = 8,
  parameter logic [7:0] SYNC_BYTE  = 8'hAA,
  parameter bit         BIG_ENDIAN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  input  logic              i_start,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [WORD_W-1:0] o_wr_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_overflow,
`ifdef LOADER_CHECKSUM_EN
  output logic              o_csum_err,
`endif
  output logic [ADDR_W:0]   o_word_count
);

  localparam int NB    = WORD_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_DONE,
    S_ERR,
    S_CSUM
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [WORD_W-1:0]  r_asm;
  logic [ADDR_W:0]    r_count;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [WORD_W-1:0]  r_wr_data;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic               r_overflow;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         r_xor;
  logic               r_csum_err;
`endif

  logic [IDX_W-1:0]   w_pos;
  logic [WORD_W-1:0]  w_word;
  logic               w_last_byte;

  // Byte lane the incoming byte lands in; big-endian fills from the MSB down.
  assign w_pos       = BIG_ENDIAN ? (IDX_W'(NB - 1) - r_idx) : r_idx;
  assign w_last_byte = (r_idx == IDX_W'(NB - 1));

  // Assembly register with the current byte merged in, so the completed word
  // can be written on the same edge that captures its final byte.
  always_comb begin
    w_word = r_asm;
    for (int i = 0; i < NB; i++) begin
      if (IDX_W'(i) == w_pos) begin
        w_word[i*8 +: 8] = i_rx_data;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_asm      <= '0;
      r_count    <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_overflow <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_xor      <= '0;
      r_csum_err <= 1'b0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_rx_valid && (i_rx_data == SYNC_BYTE)) begin
            r_state <= S_RECV;
            r_busy  <= 1'b1;
            r_count <= '0;
            r_idx   <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_xor   <= '0;
`endif
          end
        end
        S_RECV: begin
          if (i_rx_valid) begin
            r_asm <= w_word;
`ifdef LOADER_CHECKSUM_EN
            r_xor <= r_xor ^ i_rx_data;
`endif
            if (w_last_byte) begin
              r_idx     <= '0;
              r_wr_en   <= 1'b1;
              r_wr_data <= w_word;
              r_wr_addr <= r_count[ADDR_W-1:0];
              r_count   <= r_count + 1'b1;
              if (w_word == '0) begin
                // Terminator wins even at the last address.
`ifdef LOADER_CHECKSUM_EN
                r_state <= S_CSUM;
`else
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
`endif
              end else if (&r_count[ADDR_W-1:0]) begin
                r_state    <= S_ERR;
                r_busy     <= 1'b0;
                r_err      <= 1'b1;
                r_overflow <= 1'b1;
              end
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (i_rx_valid) begin
            r_busy <= 1'b0;
            if (i_rx_data == r_xor) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_ERR;
              r_err      <= 1'b1;
              r_csum_err <= 1'b1;
            end
          end
        end
`endif
        S_DONE, S_ERR: begin
          if (i_start) begin
            r_state    <= S_IDLE;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_overflow <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_csum_err <= 1'b0;
`endif
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_overflow   = r_overflow;
  assign o_word_count = r_count;
`ifdef LOADER_CHECKSUM_EN
  assign o_csum_err   = r_csum_err;
`endif

endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - directed bench for inst_loader (three configurations)
//
// DUT 0: WORD_W=32 ADDR_W=8 big-endian; DUT 1: little-endian;
// DUT 2: ADDR_W=2 big-endian (memory-full corner).
// Optional feature follows LOADER_CHECKSUM_EN.

module tb_inst_loader;

  localparam int P_IDLE = 0;
  localparam int P_RECV = 1;
  localparam int P_DONE = 2;
  localparam int P_ERR  = 3;
  localparam int P_CSUM = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       start = 1'b0;

  always #5 clk = ~clk;

  logic        we   [3];
  logic [31:0] wd   [3];
  logic [7:0]  wa   [3];
  logic [8:0]  wc   [3];
  logic        busy [3];
  logic        done [3];
  logic        err  [3];
  logic        ovf  [3];
  logic        cse  [3];
  logic [1:0]  wa2;
  logic [2:0]  wc2;

  assign wa[2] = {6'b0, wa2};
  assign wc[2] = {6'b0, wc2};
`ifndef LOADER_CHECKSUM_EN
  assign cse[0] = 1'b0;
  assign cse[1] = 1'b0;
  assign cse[2] = 1'b0;
`endif

  inst_loader #(.WORD_W(32), .ADDR_W(8), .SYNC_BYTE(8'hAA), .BIG_ENDIAN(1'b1)) u_be (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_start(start),
    .o_wr_en(we[0]), .o_wr_addr(wa[0]), .o_wr_data(wd[0]), .o_busy(busy[0]),
    .o_done(done[0]), .o_err(err[0]), .o_overflow(ovf[0]),
`ifdef LOADER_CHECKSUM_EN
    .o_csum_err(cse[0]),
`endif
    .o_word_count(wc[0])
  );

  inst_loader #(.WORD_W(32), .ADDR_W(8), .SYNC_BYTE(8'hAA), .BIG_ENDIAN(1'b0)) u_le (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_start(start),
    .o_wr_en(we[1]), .o_wr_addr(wa[1]), .o_wr_data(wd[1]), .o_busy(busy[1]),
    .o_done(done[1]), .o_err(err[1]), .o_overflow(ovf[1]),
`ifdef LOADER_CHECKSUM_EN
    .o_csum_err(cse[1]),
`endif
    .o_word_count(wc[1])
  );

  inst_loader #(.WORD_W(32), .ADDR_W(2), .SYNC_BYTE(8'hAA), .BIG_ENDIAN(1'b1)) u_sm (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_start(start),
    .o_wr_en(we[2]), .o_wr_addr(wa2), .o_wr_data(wd[2]), .o_busy(busy[2]),
    .o_done(done[2]), .o_err(err[2]), .o_overflow(ovf[2]),
`ifdef LOADER_CHECKSUM_EN
    .o_csum_err(cse[2]),
`endif
    .o_word_count(wc2)
  );

  // Behavioural model: per configuration, a phase plus the bytes of the word
  // being collected; a completed word is formed arithmetically from them.
  int        m_ph   [3];
  bit [7:0]  m_buf  [3][4];
  int        m_bn   [3];
  int        m_wcnt [3];
  bit        m_ovf  [3];
  bit        m_cse  [3];
  bit [7:0]  m_xor  [3];
  int        m_et   [3];
  int        m_ea   [3];
  bit [31:0] m_ed   [3];
  bit [31:0] m_first[3];
  int        m_aw   [3] = '{8, 8, 2};
  bit        m_big  [3] = '{1'b1, 1'b0, 1'b1};

  int        nwr      [3];
  logic [31:0] act_first[3];

  int cyc = 0;
  bit chk_on = 1'b0;
  int n_vec = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic m_byte(input int k, input bit [7:0] b, input int t);
    bit [31:0] w;
    case (m_ph[k])
      P_IDLE: if (b == 8'hAA) begin
        m_ph[k] = P_RECV; m_wcnt[k] = 0; m_bn[k] = 0; m_xor[k] = 8'h00;
      end
      P_RECV: begin
        m_buf[k][m_bn[k]] = b;
        m_bn[k]++;
        m_xor[k] ^= b;
        if (m_bn[k] == 4) begin
          w = 32'h0;
          for (int i = 0; i < 4; i++) begin
            if (m_big[k]) w = (w << 8) | 32'(m_buf[k][i]);
            else          w = w | (32'(m_buf[k][i]) << (8 * i));
          end
          m_et[k] = t; m_ea[k] = m_wcnt[k]; m_ed[k] = w;
          if (m_wcnt[k] == 0) m_first[k] = w;
          m_wcnt[k]++;
          m_bn[k] = 0;
          if (w == 32'h0) begin
`ifdef LOADER_CHECKSUM_EN
            m_ph[k] = P_CSUM;
`else
            m_ph[k] = P_DONE;
`endif
          end else if (m_wcnt[k] == (1 << m_aw[k])) begin
            m_ph[k] = P_ERR; m_ovf[k] = 1'b1;
          end
        end
      end
      P_CSUM: begin
        if (b == m_xor[k]) m_ph[k] = P_DONE;
        else begin m_ph[k] = P_ERR; m_cse[k] = 1'b1; end
      end
      default: ;
    endcase
  endtask

  task automatic send(input bit [7:0] b);
    int t;
    rx_data = b; rx_valid = 1'b1;
    t = cyc + 1;
    @(posedge clk);
    for (int k = 0; k < 3; k++) m_byte(k, b, t);
    #1;
  endtask

  task automatic send_q(input bit [7:0] q[$], input int g);
    foreach (q[i]) begin
      send(q[i]);
      if (g > 0) gap(g);
    end
  endtask

  task automatic gap(input int n);
    rx_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_rst();
    rx_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      m_ph[k] = P_IDLE; m_bn[k] = 0; m_wcnt[k] = 0; m_ovf[k] = 1'b0;
      m_cse[k] = 1'b0; m_xor[k] = 8'h00; m_et[k] = -1; nwr[k] = 0;
    end
    #1;
    rst = 1'b0;
  endtask

  task automatic do_start();
    rx_valid = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (m_ph[k] == P_DONE || m_ph[k] == P_ERR) begin
        m_ph[k] = P_IDLE; m_ovf[k] = 1'b0; m_cse[k] = 1'b0;
      end
    end
    #1;
    start = 1'b0;
  endtask

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        bit exp_we;
        exp_we = (m_et[k] == cyc);
        chk($sformatf("wr_en[%0d]", k), 64'(we[k]), 64'(exp_we));
        if (exp_we) begin
          chk($sformatf("wr_addr[%0d]", k), 64'(wa[k]), 64'(m_ea[k]));
          chk($sformatf("wr_data[%0d]", k), 64'(wd[k]), 64'(m_ed[k]));
        end
        chk($sformatf("done[%0d]", k), 64'(done[k]), 64'(m_ph[k] == P_DONE));
        chk($sformatf("err[%0d]", k), 64'(err[k]), 64'(m_ph[k] == P_ERR));
        chk($sformatf("busy[%0d]", k), 64'(busy[k]), 64'(m_ph[k] == P_RECV || m_ph[k] == P_CSUM));
        chk($sformatf("overflow[%0d]", k), 64'(ovf[k]), 64'(m_ovf[k]));
        chk($sformatf("word_count[%0d]", k), 64'(wc[k]), 64'(m_wcnt[k]));
        chk($sformatf("csum_err[%0d]", k), 64'(cse[k]), 64'(m_cse[k]));
        if (we[k] === 1'b1) begin
          nwr[k]++;
          if (wa[k] == 8'd0) act_first[k] = wd[k];
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    do_rst();
    chk_on = 1'b1;

    // Basic load with gaps between bytes.
    send_q('{8'hAA, 8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00}, 1);
    gap(3);
    chk("pin_model_be_first", 64'(m_first[0]), 64'h20010005);
    chk("pin_model_le_first", 64'(m_first[1]), 64'h05000120);
    chk("dut_be_first", 64'(act_first[0]), 64'h20010005);
    chk("dut_le_first", 64'(act_first[1]), 64'h05000120);
    chk("be_writes", 64'(nwr[0]), 64'd2);
`ifndef LOADER_CHECKSUM_EN
    chk("be_done_lit", 64'(done[0]), 64'd1);
    chk("be_wc_lit", 64'(wc[0]), 64'd2);
    do_start();
    gap(2);
    chk("be_done_after_start", 64'(done[0]), 64'd0);
    chk("be_wc_hold", 64'(wc[0]), 64'd2);
`endif

    // Memory full on the 4-word instance, back-to-back bytes.
    do_rst();
    send_q('{8'hAA, 8'h11, 8'h22, 8'h33, 8'h44, 8'h01, 8'h02, 8'h03, 8'h04,
             8'h05, 8'h06, 8'h07, 8'h08, 8'h0F, 8'h0E, 8'h0D, 8'h0C,
             8'h01, 8'h01, 8'h01, 8'h01}, 0);
    gap(3);
    chk("sm_err_lit", 64'(err[2]), 64'd1);
    chk("sm_ovf_lit", 64'(ovf[2]), 64'd1);
    chk("sm_wc_lit", 64'(wc[2]), 64'd4);
    chk("sm_writes", 64'(nwr[2]), 64'd4);
    chk("be_writes_full", 64'(nwr[0]), 64'd5);
    do_start();
    gap(2);
    chk("sm_err_cleared", 64'(err[2]), 64'd0);
    chk("sm_ovf_cleared", 64'(ovf[2]), 64'd0);

    // Noise before sync, then a continuous 8-byte burst.
    do_rst();
    send_q('{8'h55, 8'h13, 8'hAA, 8'h11, 8'h22, 8'h33, 8'h44,
             8'h00, 8'h00, 8'h00, 8'h00}, 0);
    gap(3);
    chk("burst_writes", 64'(nwr[0]), 64'd2);
    chk("burst_first", 64'(act_first[0]), 64'h11223344);

    // Reset mid-word, then a fresh load with SYNC_BYTE as data.
    do_rst();
    send_q('{8'hAA, 8'h12, 8'h34}, 0);
    do_rst();
    gap(2);
    chk("midword_no_write", 64'(nwr[0]), 64'd0);
    chk("midword_wc", 64'(wc[0]), 64'd0);
    send_q('{8'hAA, 8'hAA, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00}, 0);
    gap(3);
    chk("reload_first", 64'(act_first[0]), 64'hAA010203);

    // Terminator landing on the last address.
    do_rst();
    send_q('{8'hAA, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
             8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0);
    gap(3);
    chk("sm_last_term_ovf", 64'(ovf[2]), 64'd0);
    chk("sm_last_term_err", 64'(err[2]), 64'd0);
`ifndef LOADER_CHECKSUM_EN
    chk("sm_last_term_done", 64'(done[2]), 64'd1);
`endif

`ifdef LOADER_CHECKSUM_EN
    do_rst();
    send_q('{8'hAA, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04}, 0);
    gap(3);
    chk("csum_ok_done", 64'(done[0]), 64'd1);
    chk("csum_ok_flag", 64'(cse[0]), 64'd0);
    do_rst();
    send_q('{8'hAA, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05}, 0);
    gap(3);
    chk("csum_bad_err", 64'(err[0]), 64'd1);
    chk("csum_bad_flag", 64'(cse[0]), 64'd1);
    chk("csum_bad_ovf", 64'(ovf[0]), 64'd0);
`endif

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Parametrised UART-fed program loader for the core's instruction memory; replaces the hard-wired byte-packing LOAD mode in the CPU top.
- Waits for a sync byte, then packs incoming bytes into WORD_W-bit words and issues one write per word.
- Stops on an all-zero terminator word or on a full memory.
- Reports done/error to the core sequencer, which holds the core in reset until done=1.

Parameters:
WORD_W, 32, instruction word width in bits; must be a multiple of 8 and at least 8
ADDR_W, 8, word-address width; memory depth is 2**ADDR_W words
SYNC_BYTE, 8'hAA, byte that arms loading from IDLE
BIG_ENDIAN, 1, 1: first received byte goes to wr_data[WORD_W-1 -: 8]; 0: first byte goes to wr_data[7:0]

Ports:
clk  in  1  single clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
rx_data  in  8  received byte from uart_rx
rx_valid  in  1  one-cycle strobe; rx_data is valid while high
start  in  1  one-cycle pulse; re-arms the loader from DONE or ERR back to IDLE
wr_en  out  1  one-cycle instruction-memory write strobe
wr_addr  out  ADDR_W  word address for the write
wr_data  out  WORD_W  assembled word
busy  out  1  high in RECV (and CSUM when the optional feature is built)
done  out  1  level; high in DONE
err  out  1  level; high in ERR
overflow  out  1  sticky; set on entry to ERR due to a full memory, cleared by rst or start
word_count  out  ADDR_W+1  number of words written, including the terminator

Behaviour:
- Reset (rst=1 at clk edge) forces:
  - state to IDLE.
  - wr_en, busy, done, err, overflow to 0; wr_addr, wr_data, word_count to 0.
  - byte index to 0.
  - Reset applies in any state, including mid-word; a partial word is discarded with no write.
- States: IDLE, RECV, DONE, ERR, plus CSUM when LOADER_CHECKSUM_EN is defined.
- IDLE:
  - rx_valid with rx_data==SYNC_BYTE -> RECV; clear word_count and byte index.
  - Any other byte is ignored.
- RECV:
  - Each rx_valid shifts rx_data into the assembly register at position byte_idx, ordered per BIG_ENDIAN.
  - Each rx_valid increments byte_idx modulo WORD_W/8.
- Word completion (the byte with byte_idx == WORD_W/8-1):
  - In the next cycle: wr_en=1 for exactly one cycle, wr_data = assembled word, wr_addr = word_count[ADDR_W-1:0].
  - word_count increments in the same cycle as wr_en.
  - Write latency is 1 cycle from the final rx_valid.
- A new rx_valid in the same cycle as wr_en is accepted normally; no byte may be lost. Back-to-back rx_valid every cycle must be supported.
- Terminator:
  - A completed word equal to 0 is still written.
  - In the wr_en cycle the state moves to DONE, or to CSUM if the feature is built.
- Full memory:
  - If a non-zero word is written at wr_addr == 2**ADDR_W-1, the state moves to ERR in the wr_en cycle with overflow=1.
  - No further writes occur; wr_addr never wraps.
  - A zero word at the last address goes to DONE, not ERR.
- DONE / ERR:
  - rx_valid is ignored; outputs hold.
  - start -> IDLE; clears done, err, overflow; word_count holds until the next sync byte.
- start in IDLE or RECV has no effect.
- The SYNC_BYTE value appearing inside RECV is treated as ordinary data.
- done and err are mutually exclusive and never both high.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - A running 8-bit XOR of every data byte received in RECV is kept, including the terminator bytes.
  - After the terminator write the state is CSUM, with busy=1.
  - In CSUM the next rx_valid byte is compared with the running XOR: match -> DONE; mismatch -> ERR with overflow=0.
  - Extra output csum_err (1 bit): set on mismatch, cleared by rst or start.
- Not defined:
  - No CSUM state and no csum_err port.
  - The terminator goes directly to DONE.

Test Plan:
- WORD_W=32, BIG_ENDIAN=1: send AA, 20 01 00 05, 00 00 00 00 -> wr_en pulses at addr 0 with 32'h20010005 and at addr 1 with 0; done=1; word_count=2.
- BIG_ENDIAN=0, same stream -> addr 0 data 32'h05000120; byte order reversal verified.
- ADDR_W=2: send AA followed by four non-zero words -> four writes at addrs 0..3, then err=1, overflow=1, no fifth write; start pulse -> IDLE with err=0 and overflow=0.
- Bytes 55, 13 before AA are ignored; rx_valid held high every cycle for 8 bytes after sync -> both words written, none dropped.
- rst asserted after 2 bytes of a word -> no wr_en; all outputs 0; a fresh AA-prefixed load then writes correctly from addr 0.
- LOADER_CHECKSUM_EN: stream AA 01 02 03 04 00 00 00 00 then 04 -> done=1; same stream with final byte 05 -> err=1 and csum_err=1.
